// File: rtl/divider_seq_if.sv
// Handshake bundle between the ALU control FSM (master) and the sequential divider (slave).
interface divider_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, quot, rem, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quot, rem, div_zero
  );
endinterface

// File: rtl/divider_seq.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock.
// Divide-by-zero completes in one cycle with quot = all ones and rem = dividend.
module divider_seq #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  divider_seq_if.slave dif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] cnt_load = CW'(WIDTH);
  localparam logic [CW-1:0] cnt_one  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ZERO = 2'b10
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH:0]   r_r, r_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             dz_r, dz_s;
  logic [WIDTH-1:0] quot_r, quot_s;
  logic [WIDTH-1:0] rem_r, rem_s;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   r_diff_s;
  logic [WIDTH:0]   r_iter_s;
  logic [WIDTH-1:0] q_iter_s;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    r_shift_s = (r_r << 1) | {{WIDTH{1'b0}}, q_r[WIDTH-1]};
    r_diff_s  = r_shift_s - {1'b0, b_r};
    r_iter_s  = r_shift_s;
    q_iter_s  = {q_r[WIDTH-2:0], 1'b0};
    if (r_shift_s >= {1'b0, b_r}) begin
      r_iter_s = r_diff_s;
      q_iter_s = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      r_iter_s = r_shift_s;
      q_iter_s = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and next-output logic; results only change on a completion.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    q_s     = q_r;
    b_s     = b_r;
    r_s     = r_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    dz_s    = dz_r;
    quot_s  = quot_r;
    rem_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (dif.start) begin
          q_s    = dif.a;
          b_s    = dif.b;
          r_s    = {(WIDTH+1){1'b0}};
          busy_s = 1'b1;
          if (dif.b != {WIDTH{1'b0}}) begin
            state_s = RUN;
            cnt_s   = cnt_load;
          end else begin
            state_s = ZERO;
            cnt_s   = {CW{1'b0}};
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      RUN: begin
        q_s   = q_iter_s;
        r_s   = r_iter_s;
        cnt_s = cnt_r - cnt_one;
        if (cnt_r == cnt_one) begin
          state_s = IDLE;
          quot_s  = q_iter_s;
          rem_s   = r_iter_s[WIDTH-1:0];
          dz_s    = 1'b0;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          state_s = RUN;
        end
      end
      ZERO: begin
        state_s = IDLE;
        quot_s  = {WIDTH{1'b1}};
        rem_s   = q_r;
        dz_s    = 1'b1;
        done_s  = 1'b1;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      r_r     <= {(WIDTH+1){1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
      quot_r  <= {WIDTH{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      q_r     <= q_s;
      b_r     <= b_s;
      r_r     <= r_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      dz_r    <= dz_s;
      quot_r  <= quot_s;
      rem_r   <= rem_s;
    end
  end

  assign dif.busy     = busy_r;
  assign dif.done     = done_r;
  assign dif.quot     = quot_r;
  assign dif.rem      = rem_r;
  assign dif.div_zero = dz_r;

endmodule
